// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: debounces two push buttons, classifies short/long presses,
// steps display modes, runs the mode-0 SET state with timeout and blink, and drives four 7-segment digits.
module watch_mode_ctrl #(
  parameter int N_MODES     = 3,
  parameter int DEB_CYC     = 500_000,
  parameter int LONG_CYC    = 50_000_000,
  parameter int TIMEOUT_CYC = 1_500_000_000,
  parameter int BLINK_CYC   = 12_500_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_1_n,
  input  logic                       key_2_n,
  input  logic [N_MODES*16-1:0]      digits_in,
  output logic [$clog2(N_MODES)-1:0] mode,
  output logic                       set_active,
  output logic                       short_1,
  output logic                       short_2,
  output logic                       long_2,
  output logic [6:0]                 Hex_0,
  output logic [6:0]                 Hex_1,
  output logic [6:0]                 Hex_2,
  output logic [6:0]                 Hex_3
);

  localparam int MW = $clog2(N_MODES);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int LW = $clog2(LONG_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);

  localparam logic [MW-1:0] MODE_LAST  = MW'(N_MODES - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYC - 1);
  localparam logic [LW-1:0] LONG_LAST  = LW'(LONG_CYC - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [1:0] key_n;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] pressed;
  logic [1:0] short_ev, long_ev;

  assign key_n   = {key_2_n, key_1_n};
  assign pressed = ~sync2_q;

  // Synchronizers reset to "pressed" so a key held through reset can never look released early.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          armed_q, armed_d;
    logic          deb_q, deb_d, deb_prev_q;
    logic [LW-1:0] hold_q, hold_d;
    logic          long_done_q, long_done_d;
    logic          short_k, long_k;

    // Until armed, only a stable release is looked for; a press held across reset is ignored.
    always_comb begin
      deb_cnt_d   = deb_cnt_q;
      armed_d     = armed_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      long_k      = 1'b0;
      short_k     = deb_prev_q & ~deb_q & ~long_done_q;
      if (!armed_q) begin
        if (!pressed[k]) begin
          if (deb_cnt_q == DEB_LAST) begin
            armed_d   = 1'b1;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
          end
        end else begin
          deb_cnt_d = '0;
        end
      end else if (pressed[k] != deb_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_d     = pressed[k];
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end else begin
        deb_cnt_d = '0;
      end
      if (deb_q) begin
        if (!long_done_q) begin
          if (hold_q == LONG_LAST) begin
            long_k      = 1'b1;
            long_done_d = 1'b1;
          end else begin
            hold_d = hold_q + LW'(1);
          end
        end
      end else begin
        hold_d      = '0;
        long_done_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        deb_cnt_q   <= '0;
        armed_q     <= 1'b0;
        deb_q       <= 1'b0;
        deb_prev_q  <= 1'b0;
        hold_q      <= '0;
        long_done_q <= 1'b0;
      end else begin
        deb_cnt_q   <= deb_cnt_d;
        armed_q     <= armed_d;
        deb_q       <= deb_d;
        deb_prev_q  <= deb_q;
        hold_q      <= hold_d;
        long_done_q <= long_done_d;
      end
    end

    assign short_ev[k] = short_k;
    assign long_ev[k]  = long_k;
  end

  logic [MW-1:0] mode_q, mode_d;
  logic          set_q, set_d;
  logic [TW-1:0] to_q, to_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [1:0]    short_q;
  logic          long2_q, long2_d;
  logic          enter, blank;
  logic [15:0]   slice;
  logic [6:0]    hex_q [4];
  logic [6:0]    hex_d [4];

  always_comb begin
    slice = '0;
    for (int m = 0; m < N_MODES; m++) begin
      if (mode_q == MW'(m)) slice = digits_in[16*m +: 16];
    end
  end

  // Key-1 long wins over a coincident key-2 long; any key event reloads the SET timeout.
  always_comb begin
    mode_d      = mode_q;
    set_d       = set_q;
    to_d        = to_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    long2_d     = 1'b0;
    enter       = 1'b0;
    if (long_ev[0]) begin
      mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MW'(1);
      set_d  = 1'b0;
    end else if (long_ev[1]) begin
      if (mode_q == '0) begin
        set_d = ~set_q;
        enter = ~set_q;
      end else begin
        long2_d = 1'b1;
      end
    end
    if (|{short_ev, long_ev}) begin
      to_d = '0;
    end else if (set_q) begin
      if (to_q == TO_LAST) set_d = 1'b0;
      else                 to_d  = to_q + TW'(1);
    end
    if (enter) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (set_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    blank = set_q & blink_ph_q;
    for (int i = 0; i < 4; i++) begin
      hex_d[i] = blank ? 7'h7F : seg7(slice[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= '0;
      set_q       <= 1'b0;
      to_q        <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      short_q     <= '0;
      long2_q     <= 1'b0;
      for (int i = 0; i < 4; i++) hex_q[i] <= 7'h7F;
    end else begin
      mode_q      <= mode_d;
      set_q       <= set_d;
      to_q        <= to_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      short_q     <= short_ev;
      long2_q     <= long2_d;
      for (int i = 0; i < 4; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign mode       = mode_q;
  assign set_active = set_q;
  assign short_1    = short_q[0];
  assign short_2    = short_q[1];
  assign long_2     = long2_q;
  assign Hex_0      = hex_q[0];
  assign Hex_1      = hex_q[1];
  assign Hex_2      = hex_q[2];
  assign Hex_3      = hex_q[3];

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed scenarios with literal expectations plus random key traffic
// checked every cycle against a timeline-based behavioural model.
module tb_watch_mode_ctrl;
  localparam int NM    = 3;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int TO    = 100;
  localparam int BLINK = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_1_n = 1'b1;
  logic        key_2_n = 1'b1;
  logic [47:0] digits_in = 48'h5678_0000_1234;
  logic [1:0]  mode;
  logic        set_active, short_1, short_2, long_2;
  logic [6:0]  Hex_0, Hex_1, Hex_2, Hex_3;

  watch_mode_ctrl #(
    .N_MODES(NM), .DEB_CYC(DEB), .LONG_CYC(LONG), .TIMEOUT_CYC(TO), .BLINK_CYC(BLINK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_1_n(key_1_n), .key_2_n(key_2_n), .digits_in(digits_in),
    .mode(mode), .set_active(set_active), .short_1(short_1), .short_2(short_2), .long_2(long_2),
    .Hex_0(Hex_0), .Hex_1(Hex_1), .Hex_2(Hex_2), .Hex_3(Hex_3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int n_s1 = 0, n_s2 = 0, n_l2 = 0;

  logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    return (v <= 4'd9) ? SEG[v] : 7'h7F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per key, the sampled-input timeline (run of equal synchronized samples),
  // press start cycle and whether the press already went long; globally mode, SET entry
  // cycle and last key-event cycle, from which timeout and blink phase follow by arithmetic.
  int cyc = 0;
  bit kh0 [2], kh1 [2], run_val [2], armed [2], deb [2], deb_prev [2], fired [2];
  int run_len [2], hi_start [2];
  int m_mode = 0, m_ref = 0, m_entry = 0;
  bit m_set = 0;
  bit e_short [2];
  bit e_long2 = 0;
  logic [6:0] e_hex [4];
  bit lev [2], sev [2];

  always @(posedge clk) begin : model
    logic [15:0] sl;
    bit blank, any, p;
    bit [1:0] kn;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        kh0[k] = 0; kh1[k] = 0; run_val[k] = 1; run_len[k] = 0;
        armed[k] = 0; deb[k] = 0; deb_prev[k] = 0; fired[k] = 0; e_short[k] = 0;
      end
      m_mode = 0; m_set = 0; e_long2 = 0;
      for (int i = 0; i < 4; i++) e_hex[i] = 7'h7F;
    end else begin
      kn = {key_2_n, key_1_n};
      for (int k = 0; k < 2; k++) begin
        lev[k] = deb[k] && !fired[k] && (cyc - hi_start[k] + 1 == LONG);
        sev[k] = !deb[k] && deb_prev[k] && !fired[k];
      end
      sl = digits_in[16*m_mode +: 16];
      blank = m_set && ((((cyc - m_entry - 1) / BLINK) % 2) == 1);
      for (int i = 0; i < 4; i++) e_hex[i] = blank ? 7'h7F : seg_of(sl[4*i +: 4]);
      e_long2 = 0;
      if (lev[0]) begin
        m_mode = (m_mode + 1) % NM;
        m_set = 0;
      end else if (lev[1]) begin
        if (m_mode == 0) begin
          if (!m_set) begin m_set = 1; m_entry = cyc; end
          else m_set = 0;
        end else e_long2 = 1;
      end
      any = lev[0] | lev[1] | sev[0] | sev[1];
      if (any) m_ref = cyc;
      else if (m_set && (cyc - m_ref >= TO)) m_set = 0;
      for (int k = 0; k < 2; k++) begin
        e_short[k] = sev[k];
        p = !kh1[k];
        if (p == run_val[k]) run_len[k]++;
        else begin run_val[k] = p; run_len[k] = 1; end
        deb_prev[k] = deb[k];
        if (deb[k]) begin
          if (lev[k]) fired[k] = 1;
        end else fired[k] = 0;
        if (!armed[k]) begin
          if (!run_val[k] && run_len[k] >= DEB) armed[k] = 1;
        end else if (run_val[k] != deb[k] && run_len[k] >= DEB) begin
          deb[k] = run_val[k];
          if (deb[k]) hi_start[k] = cyc + 1;
        end
        kh1[k] = kh0[k];
        kh0[k] = kn[k];
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mode", 32'(mode), 32'(m_mode));
      chk("set_active", 32'(set_active), 32'(m_set));
      chk("short_1", 32'(short_1), 32'(e_short[0]));
      chk("short_2", 32'(short_2), 32'(e_short[1]));
      chk("long_2", 32'(long_2), 32'(e_long2));
      chk("Hex_0", 32'(Hex_0), 32'(e_hex[0]));
      chk("Hex_1", 32'(Hex_1), 32'(e_hex[1]));
      chk("Hex_2", 32'(Hex_2), 32'(e_hex[2]));
      chk("Hex_3", 32'(Hex_3), 32'(e_hex[3]));
      n_s1 += int'(short_1 === 1'b1);
      n_s2 += int'(short_2 === 1'b1);
      n_l2 += int'(long_2 === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press1(input int len);
    key_1_n = 1'b0; tick(len); key_1_n = 1'b1;
  endtask

  task automatic press2(input int len);
    key_2_n = 1'b0; tick(len); key_2_n = 1'b1;
  endtask

  initial begin
    int s0, s1, l0, t0, sel;
    int rem [2];
    bit lvl [2];
    tick(1);
    chk_en = 1;
    tick(2);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_set", 32'(set_active), 32'd0);
    chk("rst_Hex_0", 32'(Hex_0), 32'h7F);
    chk("rst_Hex_3", 32'(Hex_3), 32'h7F);
    rst_n = 1'b1;
    tick(12);

    // Short press: one short_1 pulse, mode stays 0
    s0 = n_s1;
    press1(10); tick(20);
    chk("short_press_count", 32'(n_s1 - s0), 32'd1);
    chk("short_press_mode", 32'(mode), 32'd0);

    // Mode wrap with long presses, no short pulses
    s0 = n_s1;
    for (int i = 1; i <= 3; i++) begin
      press1(30); tick(15);
      chk("wrap_mode", 32'(mode), 32'(i % 3));
    end
    chk("wrap_no_short", 32'(n_s1 - s0), 32'd0);

    // Glitch rejection
    s1 = n_s2; l0 = n_l2;
    press2(3); tick(15);
    chk("glitch_short2", 32'(n_s2 - s1), 32'd0);
    chk("glitch_long2", 32'(n_l2 - l0), 32'd0);
    chk("glitch_set", 32'(set_active), 32'd0);

    // SET entry, blink and timeout in mode 0 (digit 0 is 4)
    l0 = n_l2; t0 = -1;
    key_2_n = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 30) key_2_n = 1'b1;
      if (t0 < 0 && set_active === 1'b1) t0 = n;
      if (t0 > 0) begin
        if (n == t0)       chk("blink_vis_a", 32'(Hex_0), 32'h19);
        if (n == t0 + 8)   chk("blink_vis_b", 32'(Hex_0), 32'h19);
        if (n == t0 + 9)   chk("blink_blank_a", 32'(Hex_0), 32'h7F);
        if (n == t0 + 16)  chk("blink_blank_b", 32'(Hex_3), 32'h7F);
        if (n == t0 + 17)  chk("blink_vis_c", 32'(Hex_0), 32'h19);
        if (n == t0 + 99)  chk("set_before_to", 32'(set_active), 32'd1);
        if (n == t0 + 100) chk("set_after_to", 32'(set_active), 32'd0);
      end
    end
    chk("set_entered", 32'(t0 > 0), 32'd1);
    chk("set_no_long2", 32'(n_l2 - l0), 32'd0);

    // Display decode in mode 1
    press1(30); tick(15);
    chk("disp_mode", 32'(mode), 32'd1);
    digits_in[31:16] = 16'h12F9;
    tick(2);
    chk("disp_Hex_0", 32'(Hex_0), 32'h10);
    chk("disp_Hex_1", 32'(Hex_1), 32'h7F);
    chk("disp_Hex_2", 32'(Hex_2), 32'h24);
    chk("disp_Hex_3", 32'(Hex_3), 32'h79);

    // Coincident long presses from mode 0
    press1(30); tick(15);
    press1(30); tick(15);
    chk("coin_start_mode", 32'(mode), 32'd0);
    l0 = n_l2;
    key_1_n = 1'b0; key_2_n = 1'b0;
    tick(25);
    key_1_n = 1'b1; key_2_n = 1'b1;
    tick(20);
    chk("coin_mode", 32'(mode), 32'd1);
    chk("coin_set", 32'(set_active), 32'd0);
    chk("coin_long2", 32'(n_l2 - l0), 32'd0);

    // Key held through reset is ignored
    s0 = n_s1;
    key_1_n = 1'b0;
    rst_n = 1'b0; tick(3); rst_n = 1'b1;
    tick(40);
    key_1_n = 1'b1;
    tick(20);
    chk("held_rst_mode", 32'(mode), 32'd0);
    chk("held_rst_short", 32'(n_s1 - s0), 32'd0);

    // Random key traffic with occasional resets and digit changes
    rem[0] = 0; rem[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 799) != 0);
      for (int k = 0; k < 2; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = !lvl[k];
          sel = int'($urandom_range(0, 2));
          if (lvl[k])
            rem[k] = (sel == 0) ? int'($urandom_range(1, 3)) :
                     (sel == 1) ? int'($urandom_range(5, 15)) : int'($urandom_range(22, 40));
          else
            rem[k] = (sel == 0) ? int'($urandom_range(1, 3)) :
                     (sel == 1) ? int'($urandom_range(5, 20)) : int'($urandom_range(100, 140));
        end
        rem[k]--;
      end
      key_1_n = !lvl[0];
      key_2_n = !lvl[1];
      if ($urandom_range(0, 49) == 0) digits_in = 48'({$urandom(), $urandom()});
    end
    rst_n = 1'b1; key_1_n = 1'b1; key_2_n = 1'b1;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/watch_mode_ctrl.md
WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 SHALL have parameter N_MODES, default 3, number of display modes; legal range 2..8; mode 0 is the watch.
REQ-002 SHALL have parameter DEB_CYC, default 500_000, cycles a synchronized key level must be stable before it is accepted.
REQ-003 SHALL have parameter LONG_CYC, default 50_000_000, debounced-press cycles before a long press is declared.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1_500_000_000, cycles with no accepted key event in SET before SET is forced off.
REQ-005 SHALL have parameter BLINK_CYC, default 12_500_000, half-period of the SET blink.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port key_1_n, input, 1, asynchronous active-low push button 1.
REQ-009 SHALL have port key_2_n, input, 1, asynchronous active-low push button 2.
REQ-010 SHALL have port digits_in, input, N_MODES*16, four BCD digits per mode; mode m occupies bits [16m+15:16m]; digit 0 is the low nibble.
REQ-011 SHALL have port mode, output, $clog2(N_MODES), currently displayed mode.
REQ-012 SHALL have port set_active, output, 1, high while mode 0 is in SET.
REQ-013 SHALL have port short_1 and short_2, output, 1 each, one-cycle pulses for short presses forwarded to the active mode.
REQ-014 SHALL have port long_2, output, 1, one-cycle pulse for a key-2 long press forwarded to the active mode.
REQ-015 SHALL have ports Hex_0..Hex_3, output, 7 each, active-low segments, bit0=a..bit6=g; Hex_0 shows digit 0.

Function
REQ-016 SHALL pass each key through a 2-FF synchronizer and invert it, giving the pressed level.
REQ-017 SHALL change a debounced key level only after the synchronized level differs from it for DEB_CYC consecutive cycles; a shorter glitch restarts the count.
REQ-018 SHALL, per key, count debounced-pressed cycles; on reaching LONG_CYC, it SHALL emit one internal long event and no further event until release.
REQ-019 SHALL emit an internal short event in the cycle the debounced level falls if no long event occurred in that press.
REQ-020 SHALL advance mode on a key-1 long event as mode+1 and wrap from N_MODES-1 to 0; this event SHALL not be forwarded.
REQ-021 SHALL, on a key-2 long event in mode 0, toggle set_active and not pulse long_2; in modes other than 0 it SHALL pulse long_2.
REQ-022 SHALL clear set_active on any mode change.
REQ-023 SHALL clear set_active when TIMEOUT_CYC cycles elapse in SET without an accepted key event; any key event SHALL reload the timeout counter.
REQ-024 SHALL drive short_1 and short_2 exactly one cycle after the internal short event, in every mode including SET.
REQ-025 SHALL, when key-1 and key-2 long events coincide, act on key 1 only and drop the key-2 long event.
REQ-026 SHALL select the digits_in slice by mode and decode each nibble 0-9 to standard segments (0 = 7'b1000000); values 10-15 SHALL give blank (7'h7F).
REQ-027 SHALL, while set_active, blank all four digits during alternate BLINK_CYC periods, starting visible; the blink counter SHALL restart when SET is entered.
REQ-028 SHALL register Hex outputs, giving a latency of 1 cycle from a change in digits_in or mode.

Reset
REQ-029 SHALL, while rst_n=0 at a clk edge, set mode=0, set_active=0, short_1=short_2=long_2=0, counters=0, debounced levels=released, and Hex_0..3=7'h7F.
REQ-030 SHALL, after reset with a key still held, ignore that press until the key has been debounced released; no short or long event SHALL occur for it.
REQ-031 SHALL, on a reset asserted mid-press or in SET, abandon the press and SET state with no pulse emitted.

Verification (bench parameters: DEB_CYC=4, LONG_CYC=20, TIMEOUT_CYC=100, BLINK_CYC=8, N_MODES=3)
REQ-032 SHALL cover the short press: key_1_n low 10 cycles then high -> exactly one short_1 pulse; mode unchanged at 0.
REQ-033 SHALL cover mode wrap: three key-1 long presses -> mode steps 1, 2, 0; no short_1 pulses.
REQ-034 SHALL cover glitch rejection: key_2_n low 3 cycles -> no events; debounced level unchanged.
REQ-035 SHALL cover SET and timeout: key-2 long press in mode 0 -> set_active=1 and Hex blank/visible alternating every 8 cycles; no keys for 100 cycles -> set_active=0.
REQ-036 SHALL cover the display: mode 1 with digits_in[31:16]=16'h12F9 -> Hex_0=7'b0010000, Hex_1=7'h7F, Hex_2=7'b0100100, Hex_3=7'b1111001.
REQ-037 SHALL cover the coincident long presses: both keys pressed together for 25 cycles in mode 0 -> mode=1, set_active=0, no long_2 pulse.
